// File: rtl/mult_div_unit_if.sv
// Execute-stage handshake bundle for the HI/LO multiply/divide unit.
// The master drives requests and MT writes; the slave reports busy/done/HI/LO.
interface mult_div_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  i_Start;
   logic [1:0]            i_Op;
   logic [DATA_WIDTH-1:0] i_SrcA;
   logic [DATA_WIDTH-1:0] i_SrcB;
   logic                  i_Flush;
   logic                  i_MTHI;
   logic                  i_MTLO;
   logic [DATA_WIDTH-1:0] i_WriteData;
   logic                  o_Busy;
   logic                  o_Done;
   logic                  o_DivByZero;
   logic [DATA_WIDTH-1:0] o_HI;
   logic [DATA_WIDTH-1:0] o_LO;

   modport master (
      output i_Start, i_Op, i_SrcA, i_SrcB,
      output i_Flush, i_MTHI, i_MTLO, i_WriteData,
      input  o_Busy, o_Done, o_DivByZero, o_HI, o_LO
   );

   modport slave (
      input  i_Start, i_Op, i_SrcA, i_SrcB,
      input  i_Flush, i_MTHI, i_MTLO, i_WriteData,
      output o_Busy, o_Done, o_DivByZero, o_HI, o_LO
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Operates on magnitudes in RUN and applies sign correction in FIX.
module mult_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input logic              i_CLK,
   input logic              i_RST,
   mult_div_unit_if.slave   bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t         state;
   state_t         nextState;
   logic [CW-1:0]  cnt;
   logic [1:0]     opReg;
   logic           negA;
   logic           negB;
   logic [W-1:0]   acc;
   logic [W-1:0]   mq;
   logic [W-1:0]   bReg;
   logic [W-1:0]   hiReg;
   logic [W-1:0]   loReg;
   logic           doneReg;
   logic           dbzReg;

   logic           busy;
   logic           accept;
   logic           stepEn;
   logic           fixEn;

   logic           inSigned;
   logic [W-1:0]   magA;
   logic [W-1:0]   magB;
   logic [W:0]     mulSum;
   logic [W:0]     divT;
   logic           divGe;
   logic [W-1:0]   divSub;
   logic           negRes;
   logic [2*W-1:0] prodFix;
   logic [W-1:0]   quot;
   logic [W-1:0]   rem;
   logic           bZero;

   always_ff @(posedge i_CLK) begin
      if (i_RST) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (bus.i_Start && !bus.i_Flush) nextState = RUN;
         RUN: begin
            if (bus.i_Flush)   nextState = IDLE;
            else if (cnt == '0) nextState = FIX;
         end
         FIX:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != IDLE);
      accept = (state == IDLE) && bus.i_Start && !bus.i_Flush;
      stepEn = (state == RUN) && !bus.i_Flush;
      fixEn  = (state == FIX) && !bus.i_Flush;
   end

   always_comb begin
      inSigned = !bus.i_Op[0];
      magA     = (inSigned && bus.i_SrcA[W-1]) ? -bus.i_SrcA : bus.i_SrcA;
      magB     = (inSigned && bus.i_SrcB[W-1]) ? -bus.i_SrcB : bus.i_SrcB;
      mulSum   = {1'b0, acc} + (mq[0] ? {1'b0, bReg} : '0);
      divT     = {acc, mq[W-1]};
      divGe    = divT >= {1'b0, bReg};
      divSub   = divT[W-1:0] - bReg;
      negRes   = negA ^ negB;
      prodFix  = negRes ? -{acc, mq} : {acc, mq};
      quot     = negRes ? -mq : mq;
      rem      = negA ? -acc : acc;
      bZero    = (bReg == '0);
   end

   // Datapath: multiply shifts {acc,mq} right, divide shifts it left.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         cnt     <= '0;
         opReg   <= '0;
         negA    <= 1'b0;
         negB    <= 1'b0;
         acc     <= '0;
         mq      <= '0;
         bReg    <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         doneReg <= 1'b0;
         dbzReg  <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         if (accept) begin
            opReg <= bus.i_Op;
            negA  <= inSigned && bus.i_SrcA[W-1];
            negB  <= inSigned && bus.i_SrcB[W-1];
            acc   <= '0;
            mq    <= magA;
            bReg  <= magB;
            cnt   <= CW'(W - 1);
         end else if (state == IDLE) begin
            if (bus.i_MTHI) hiReg <= bus.i_WriteData;
            if (bus.i_MTLO) loReg <= bus.i_WriteData;
         end
         if (stepEn) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            if (opReg[1]) begin
               acc <= divGe ? divSub : divT[W-1:0];
               mq  <= {mq[W-2:0], divGe};
            end else begin
               acc <= mulSum[W:1];
               mq  <= {mulSum[0], mq[W-1:1]};
            end
         end
         if (fixEn) begin
            doneReg <= 1'b1;
            dbzReg  <= opReg[1] && bZero;
            if (opReg[1]) begin
               hiReg <= rem;
               loReg <= bZero ? '1 : quot;
            end else begin
               {hiReg, loReg} <= prodFix;
            end
         end
      end
   end

   assign bus.o_Busy      = busy;
   assign bus.o_Done      = doneReg;
   assign bus.o_DivByZero = dbzReg;
   assign bus.o_HI        = hiReg;
   assign bus.o_LO        = loReg;
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, operand and HI/LO width; SHALL be an even value of at least 8.
REQ-002 i_CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 i_RST  input  1  reset, synchronous, active-high.
REQ-004 i_Start  input  1  request a new operation (execute stage).
REQ-005 i_Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with i_Start.
REQ-006 i_SrcA / i_SrcB  input  DATA_WIDTH each  multiplicand/dividend, multiplier/divisor; sampled with i_Start.
REQ-007 i_Flush  input  1  abort the in-flight operation (FlushE).
REQ-008 i_MTHI / i_MTLO  input  1 each  direct write of i_WriteData into HI / LO.
REQ-009 i_WriteData  input  DATA_WIDTH  data for MTHI/MTLO.
REQ-010 o_Busy  output  1  operation in flight; the hazard unit stalls on it.
REQ-011 o_Done  output  1  one-cycle pulse: HI/LO just updated by an operation.
REQ-012 o_DivByZero  output  1  qualifies o_Done; last divide had divisor 0.
REQ-013 o_HI / o_LO  output  DATA_WIDTH each  architectural HI/LO registers.

Function
REQ-014 FSM states: IDLE, RUN, FIX; o_Busy SHALL be 1 in RUN and FIX, 0 in IDLE.
REQ-015 Accept: in IDLE with i_Start=1 and i_Flush=0; operands and op latched, state goes to RUN, iteration counter loaded with DATA_WIDTH-1.
REQ-016 RUN: one radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes; counter decrements; at 0 the state goes to FIX.
REQ-017 FIX: sign correction for signed ops, result written to HI/LO, state goes to IDLE.
REQ-018 Latency: accept on edge 0 -> o_Busy=1 after edges 0..DATA_WIDTH; HI/LO hold the result and o_Done=1 after edge DATA_WIDTH+1, for exactly one cycle.
REQ-019 Multiply: {HI,LO} = full 2*DATA_WIDTH-bit product; signed (MULT) or unsigned (MULTU).
REQ-020 Divide: LO = quotient, HI = remainder; signed quotient truncates toward zero; the signed remainder takes the dividend's sign.
REQ-021 Divisor 0: HI = dividend, LO = all ones, o_DivByZero=1 with o_Done; same latency as any other divide.
REQ-022 Signed overflow (most-negative / -1): LO = most-negative, HI = 0, o_DivByZero=0.
REQ-023 o_DivByZero SHALL hold its value until the next o_Done.
REQ-024 i_Start while busy SHALL be ignored; no queuing.
REQ-025 i_Flush in RUN or FIX: next state IDLE, HI/LO unchanged, no o_Done; i_Flush together with i_Start in IDLE blocks the accept.
REQ-026 MTHI/MTLO act only in IDLE with no accepted i_Start; HI/LO update on that edge; ignored while busy; an accepted i_Start wins over a simultaneous MT write; MTHI and MTLO together write both.
REQ-027 Outputs SHALL be registered; o_HI/o_LO change only at an FIX exit or an MT write.

Reset
REQ-028 i_RST=1 at an edge: state IDLE, counter 0, HI=0, LO=0, o_Busy=0, o_Done=0, o_DivByZero=0.
REQ-029 Reset mid-operation SHALL discard the operation with no o_Done; reset has priority over i_Flush, i_Start and MT writes.

Verification (DATA_WIDTH=32)
REQ-030 MULT 0xFFFFFFFE x 0x00000003 -> after edge 33: HI=0xFFFFFFFF, LO=0xFFFFFFFA, o_Done=1 for 1 cycle; o_Busy=1 for 33 cycles.
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 DIVU 100 / 0 -> HI=0x00000064, LO=0xFFFFFFFF, o_DivByZero=1.
REQ-034 Flush test: MTLO 0x1234, then start DIVU, i_Flush in RUN cycle 10 -> o_Busy=0 next cycle, LO=0x1234, no o_Done; i_Start in a busy cycle is ignored.
REQ-035 Reset test: i_RST asserted in RUN cycle 5 -> all outputs 0 on the next cycle; i_Start with MTHI in IDLE -> HI unchanged, operation runs.
